// File: rtl/arith_pkg.sv
// Shared opcodes, FSM encoding and small decode helpers for the sequential
// arithmetic unit and its iterative mul/div core.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iterative core personality, chosen once at load time.
    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } core_mode_t;

    // Mul and div are the two opcodes that need the multi-cycle core.
    function automatic logic is_iter_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic core_mode_t op_to_mode(input logic [1:0] op);
        return (op == OP_DIV) ? MODE_DIV : MODE_MUL;
    endfunction

endpackage

// File: rtl/seq_arith_unit_if.sv
// Request/response bundle of the sequential arithmetic unit: start/busy/done
// handshake, operands in, registered result and status flags out.
interface seq_arith_unit_if #(
    parameter int WIDTH = 4
);

    logic                   start;
    logic [1:0]             operation;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     returnValue;
    logic                   overflow;
    logic                   divByZero;

    modport master (
        output start,
        output operation,
        output x,
        output y,
        input  busy,
        input  done,
        input  returnValue,
        input  overflow,
        input  divByZero
    );

    modport slave (
        input  start,
        input  operation,
        input  x,
        input  y,
        output busy,
        output done,
        output returnValue,
        output overflow,
        output divByZero
    );

endinterface

// File: rtl/arith_iter_core.sv
// Shared multi-cycle engine: WIDTH shift-add multiply steps or WIDTH restoring
// divide steps on one 2*WIDTH shift register and one WIDTH+1-bit adder.
module arith_iter_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  core_mode_t           mode,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] sr;
    logic [WIDTH-1:0]   opd;
    core_mode_t         mode_q;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] step_val;

    // Mul: sr = {acc, multiplier}. Div: sr = {remainder, dividend/quotient};
    // the remainder window is widened by the next dividend bit before the trial subtract.
    always_comb begin
        add_b = {1'b0, opd};
        if (mode_q == MODE_DIV) begin
            add_a = sr[2*WIDTH-1:WIDTH-1];
            add_s = add_a - add_b;
        end else begin
            add_a = {1'b0, sr[2*WIDTH-1:WIDTH]};
            add_s = add_a + add_b;
        end
    end

    always_comb begin
        if (mode_q == MODE_DIV) begin
            if (add_s[WIDTH])
                step_val = {sr[2*WIDTH-2:0], 1'b0};
            else
                step_val = {add_s[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
        end else begin
            if (sr[0])
                step_val = {add_s, sr[WIDTH-1:1]};
            else
                step_val = {1'b0, sr[2*WIDTH-1:1]};
        end
    end

    // result is the value the register takes on this step, so the caller can
    // register it on the same edge that retires the final iteration.
    assign result = step_val;
    assign last   = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (load) begin
            sr     <= {{WIDTH{1'b0}}, a};
            opd    <= b;
            mode_q <= mode;
        end else if (step) begin
            sr     <= step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CW'(WIDTH);
        else if (step && (cnt != '0))
            cnt <= cnt - CW'(1);
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential unsigned add/sub/mul/div unit with start/busy/done handshake;
// add/sub resolve at accept, mul/div run WIDTH iterations in arith_iter_core.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    seq_arith_unit_if.slave  bus
);

    state_t               state;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 overflow_r;
    logic                 div_zero_r;

    logic                 accept;
    logic                 div_zero;
    logic                 core_load;
    logic                 core_step;
    logic                 core_last;
    logic [2*WIDTH-1:0]   core_result;
    logic [WIDTH:0]       addsub;

    always_comb begin
        accept    = (state == ST_IDLE) && bus.start;
        div_zero  = (bus.operation == OP_DIV) && (bus.y == '0);
        core_load = accept && is_iter_op(bus.operation) && !div_zero;
        core_step = (state == ST_CALC);
        // Bit WIDTH is the carry-out on add and the borrow on sub.
        if (bus.operation == OP_SUB)
            addsub = {1'b0, bus.x} - {1'b0, bus.y};
        else
            addsub = {1'b0, bus.x} + {1'b0, bus.y};
    end

    arith_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clock),
        .rst    (reset),
        .load   (core_load),
        .mode   (op_to_mode(bus.operation)),
        .step   (core_step),
        .a      (bus.x),
        .b      (bus.y),
        .result (core_result),
        .last   (core_last)
    );

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            overflow_r <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        busy_r <= 1'b1;
                        if (!is_iter_op(bus.operation)) begin
                            state      <= ST_DONE;
                            done_r     <= 1'b1;
                            result_r   <= {{WIDTH{1'b0}}, addsub[WIDTH-1:0]};
                            overflow_r <= addsub[WIDTH];
                            div_zero_r <= 1'b0;
                        end else if (div_zero) begin
                            state      <= ST_DONE;
                            done_r     <= 1'b1;
                            result_r   <= {bus.x, {WIDTH{1'b1}}};
                            overflow_r <= 1'b0;
                            div_zero_r <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (core_last) begin
                        state      <= ST_DONE;
                        done_r     <= 1'b1;
                        result_r   <= core_result;
                        overflow_r <= 1'b0;
                        div_zero_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.returnValue = result_r;
    assign bus.overflow    = overflow_r;
    assign bus.divByZero   = div_zero_r;

endmodule
